// File: rtl/alu_pkg.sv
// Shared opcodes, FSM states and flag bundle for the Y86-64 ALU.
// Consumers: alu_cc_seq, alu_mul_iter.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// W-cycle shift-add signed multiplier over operand magnitudes.
// The sign is applied to the final sum; done_o marks the last cycle.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);

  localparam int CW = $clog2(W);

  logic           run_q;
  logic [CW-1:0]  cnt_q;
  logic           neg_q;
  logic [2*W-1:0] mcand_q;
  logic [W-1:0]   mplier_q;
  logic [2*W-1:0] acc_q;
  logic [2*W-1:0] acc_d;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;

  assign a_mag = a_i[W-1] ? -a_i : a_i;
  assign b_mag = b_i[W-1] ? -b_i : b_i;

  // Accumulate this cycle's partial product and form the signed result.
  always_comb begin
    acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
    done_o = run_q && (cnt_q == CW'(W - 1));
    prod_o = neg_q ? -acc_d : acc_d;
  end

  // Iteration state: one multiplier bit consumed per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start_i) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      neg_q    <= a_i[W-1] ^ b_i[W-1];
      mcand_q  <= {{W{1'b0}}, a_mag};
      mplier_q <= b_mag;
      acc_q    <= '0;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_cc_seq.sv
// Sequential Y86-64 ALU with registered result, flags and CC register.
// Optional iterative multiply enabled by macro ALU_CC_MUL_EN.
module alu_cc_seq
  import alu_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   opcode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         set_cc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         illegal,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [W-1:0] res_q, res_d;
  flags_t       flg_q, flg_d;
  flags_t       cc_q, cc_d;
  logic         ill_q, ill_d;
  logic         vld_q, vld_d;
  logic         fire;
  logic [W-1:0] alu_res;
  logic         alu_of;
  flags_t       alu_fl;
  logic         legal;
  logic         is_mul;

  assign in_ready = (state_q == S_IDLE)
                 && (!vld_q || out_ready);
  assign fire = in_valid && in_ready;

  // Single-cycle ops: result, overflow and legality decode.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    legal   = 1'b1;
    is_mul  = 1'b0;
    unique case (1'b1)
      (opcode == OP_ADD): begin
        alu_res = a + b;
        alu_of  = (a[W-1] == b[W-1])
               && (alu_res[W-1] != a[W-1]);
      end
      (opcode == OP_SUB): begin
        alu_res = a - b;
        alu_of  = (a[W-1] != b[W-1])
               && (alu_res[W-1] != a[W-1]);
      end
      (opcode == OP_AND): alu_res = a & b;
      (opcode == OP_XOR): alu_res = a ^ b;
`ifdef ALU_CC_MUL_EN
      (opcode == OP_MUL): is_mul = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    alu_fl = legal
      ? flags_t'{alu_res == '0, alu_res[W-1], alu_of}
      : flags_t'(3'b000);
  end

`ifdef ALU_CC_MUL_EN
  logic           mul_done;
  logic [2*W-1:0] mul_prod;
  logic [W-1:0]   mul_res;
  flags_t         mul_fl;
  logic           pcc_q;

  alu_mul_iter #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (fire && is_mul),
    .a_i     (a),
    .b_i     (b),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  assign mul_res = mul_prod[W-1:0];
  assign mul_fl = flags_t'{
    mul_res == '0,
    mul_res[W-1],
    mul_prod[2*W-1:W] != {W{mul_res[W-1]}}
  };

  // Remember whether the in-flight multiply commits its flags.
  always_ff @(posedge clk) begin
    if (!rst_n) pcc_q <= 1'b0;
    else if (fire && is_mul) pcc_q <= set_cc;
  end

  assign busy = (state_q == S_MUL);
`else
  assign busy = 1'b0;
`endif

  // Next state, output register load and CC commit.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flg_d   = flg_q;
    ill_d   = ill_q;
    cc_d    = cc_q;
    vld_d   = vld_q && !out_ready;
    unique case (state_q)
      S_IDLE: begin
        if (fire && is_mul) begin
          state_d = S_MUL;
        end else if (fire) begin
          vld_d = 1'b1;
          res_d = alu_res;
          flg_d = alu_fl;
          ill_d = !legal;
          if (set_cc && legal) cc_d = alu_fl;
        end
      end
      S_MUL: begin
`ifdef ALU_CC_MUL_EN
        if (mul_done) begin
          state_d = S_IDLE;
          vld_d   = 1'b1;
          res_d   = mul_res;
          flg_d   = mul_fl;
          ill_d   = 1'b0;
          if (pcc_q) cc_d = mul_fl;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      flg_q   <= '0;
      cc_q    <= '0;
      ill_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      cc_q    <= cc_d;
      ill_q   <= ill_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign res       = res_q;
  assign zf        = flg_q.zf;
  assign sf        = flg_q.sf;
  assign of        = flg_q.of;
  assign illegal   = ill_q;
  assign cc_zf     = cc_q.zf;
  assign cc_sf     = cc_q.sf;
  assign cc_of     = cc_q.of;

endmodule

// File: tb/tb_alu_cc_seq.sv
// Directed self-checking bench for alu_cc_seq (W=64).
// MUL scenarios are included when ALU_CC_MUL_EN is defined.
module tb_alu_cc_seq;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         set_cc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         zf, sf, of;
  logic         illegal;
  logic         cc_zf, cc_sf, cc_of;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_cc_seq #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a),
    .b         (b),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zf        (zf),
    .sf        (sf),
    .of        (of),
    .illegal   (illegal),
    .cc_zf     (cc_zf),
    .cc_sf     (cc_sf),
    .cc_of     (cc_of),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [2:0] op,
                       input logic [W-1:0] av,
                       input logic [W-1:0] bv,
                       input logic sc);
    in_valid = 1'b1;
    opcode   = op;
    a        = av;
    b        = bv;
    set_cc   = sc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    opcode = 3'b000;
    a = '0;
    b = '0;
    set_cc = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if ({out_valid, res, zf, sf, of, illegal, busy}
        !== {1'b0, {W{1'b0}}, 5'b0}) begin
      n_bad++;
      $display("FAIL reset_out: vld=%b res=%h f=%b%b%b ill=%b busy=%b want all 0",
               out_valid, res, zf, sf, of, illegal, busy);
    end
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of, in_ready} !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_cc_rdy: cc=%b%b%b rdy=%b want cc=000 rdy=1",
               cc_zf, cc_sf, cc_of, in_ready);
    end
  endtask

  task automatic test_add();
    offer(3'b000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, res} !== {1'b1, 64'h8000_0000_0000_0000}) begin
      n_bad++;
      $display("FAIL add_res: vld=%b res=%h want 1 8000000000000000",
               out_valid, res);
    end
    n_cmp++;
    if ({zf, sf, of, illegal} !== 4'b0110) begin
      n_bad++;
      $display("FAIL add_flags: zsoi=%b%b%b%b want 0110",
               zf, sf, of, illegal);
    end
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin
      n_bad++;
      $display("FAIL add_cc: cc=%b%b%b want 011", cc_zf, cc_sf, cc_of);
    end
  endtask

  task automatic test_sub();
    offer(3'b001, 64'd5, 64'd5, 1'b0);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, res, zf, sf, of} !== {1'b1, {W{1'b0}}, 3'b100}) begin
      n_bad++;
      $display("FAIL sub_zero: vld=%b res=%h zso=%b%b%b want 1 0 100",
               out_valid, res, zf, sf, of);
    end
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin
      n_bad++;
      $display("FAIL sub_cc_hold: cc=%b%b%b want 011", cc_zf, cc_sf, cc_of);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL sub_drain: vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    offer(3'b011, 64'hF0, 64'hFF, 1'b0);
    tick();
    offer(3'b010, 64'hC, 64'hA, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({out_valid, res, in_ready} !== {1'b1, 64'h0F, 1'b0}) begin
        n_bad++;
        $display("FAIL bp_hold%0d: vld=%b res=%h rdy=%b want 1 0f 0",
                 i, out_valid, res, in_ready);
      end
      tick();
    end
    n_cmp++;
    if ({out_valid, res} !== {1'b1, 64'h0F}) begin
      n_bad++;
      $display("FAIL bp_last: vld=%b res=%h want 1 0f", out_valid, res);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, res} !== {1'b1, 64'h8}) begin
      n_bad++;
      $display("FAIL bp_swap: vld=%b res=%h want 1 8", out_valid, res);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_nodup: vld=%b want 0", out_valid);
    end
  endtask

  task automatic test_illegal();
    offer(3'b111, 64'd9, 64'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, illegal, res, zf, sf, of}
        !== {2'b11, {W{1'b0}}, 3'b000}) begin
      n_bad++;
      $display("FAIL ill_111: vld=%b ill=%b res=%h f=%b%b%b want 1 1 0 000",
               out_valid, illegal, res, zf, sf, of);
    end
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b011) begin
      n_bad++;
      $display("FAIL ill_cc: cc=%b%b%b want 011", cc_zf, cc_sf, cc_of);
    end
`ifndef ALU_CC_MUL_EN
    offer(3'b100, 64'd2, 64'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, illegal, res, busy, cc_zf, cc_sf, cc_of}
        !== {2'b11, {W{1'b0}}, 4'b0011}) begin
      n_bad++;
      $display("FAIL ill_100: vld=%b ill=%b res=%h busy=%b cc=%b%b%b",
               out_valid, illegal, res, busy, cc_zf, cc_sf, cc_of);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [2:0]   ops [4] = '{3'b000, 3'b001, 3'b010, 3'b001};
    logic [W-1:0] av  [4] = '{64'd1, 64'd2, 64'hFF00,
                              64'h8000_0000_0000_0000};
    logic [W-1:0] bv  [4] = '{64'd2, 64'd3, 64'h0FF0, 64'd1};
    logic         sc  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] er  [4] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h0F00, 64'h7FFF_FFFF_FFFF_FFFF};
    logic [2:0]   ef  [4] = '{3'b000, 3'b010, 3'b000, 3'b001};
    logic [2:0]   ec  [4] = '{3'b011, 3'b011, 3'b011, 3'b001};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(ops[i], av[i], bv[i], sc[i]);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_rdy%0d: rdy=%b want 1", i, in_ready);
      end
      tick();
      n_cmp++;
      if ({out_valid, res, zf, sf, of, cc_zf, cc_sf, cc_of}
          !== {1'b1, er[i], ef[i], ec[i]}) begin
        n_bad++;
        $display("FAIL b2b_%0d: vld=%b res=%h f=%b%b%b cc=%b%b%b want 1 %h %b %b",
                 i, out_valid, res, zf, sf, of, cc_zf, cc_sf, cc_of,
                 er[i], ef[i], ec[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

`ifdef ALU_CC_MUL_EN
  task automatic test_mul();
    logic [W-1:0] m3;
    m3 = -64'sd3;
    out_ready = 1'b1;
    offer(3'b100, m3, 64'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      n_cmp++;
      if ({busy, out_valid, in_ready} !== 3'b100) begin
        n_bad++;
        $display("FAIL mul_busy%0d: busy=%b vld=%b rdy=%b want 100",
                 i, busy, out_valid, in_ready);
      end
      tick();
    end
    n_cmp++;
    if ({busy, out_valid, res, zf, sf, of}
        !== {2'b01, 64'hFFFF_FFFF_FFFF_FFEB, 3'b010}) begin
      n_bad++;
      $display("FAIL mul_neg: busy=%b vld=%b res=%h f=%b%b%b want 0 1 ..ffeb 010",
               busy, out_valid, res, zf, sf, of);
    end
    n_cmp++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b010) begin
      n_bad++;
      $display("FAIL mul_cc: cc=%b%b%b want 010", cc_zf, cc_sf, cc_of);
    end
    offer(3'b100, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) tick();
    n_cmp++;
    if ({out_valid, res, zf, sf, of, cc_zf, cc_sf, cc_of}
        !== {1'b1, {W{1'b0}}, 3'b101, 3'b010}) begin
      n_bad++;
      $display("FAIL mul_ovf: vld=%b res=%h f=%b%b%b cc=%b%b%b want 1 0 101 010",
               out_valid, res, zf, sf, of, cc_zf, cc_sf, cc_of);
    end
    tick();
  endtask

  task automatic test_reset_mid_mul();
    offer(3'b100, 64'd5, 64'd5, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({busy, out_valid, cc_zf, cc_sf, cc_of, in_ready} !== 6'b000001) begin
      n_bad++;
      $display("FAIL rst_mul: busy=%b vld=%b cc=%b%b%b rdy=%b want 0 0 000 1",
               busy, out_valid, cc_zf, cc_sf, cc_of, in_ready);
    end
    rst_n = 1'b1;
    tick();
  endtask
`endif

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    offer(3'b000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, res, zf, cc_zf, cc_sf, cc_of, in_ready}
        !== {1'b0, {W{1'b0}}, 5'b00001}) begin
      n_bad++;
      $display("FAIL rst_stall: vld=%b res=%h zf=%b cc=%b%b%b rdy=%b",
               out_valid, res, zf, cc_zf, cc_sf, cc_of, in_ready);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_illegal();
    test_back_to_back();
`ifdef ALU_CC_MUL_EN
    test_mul();
    test_reset_mid_mul();
`endif
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
